// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file and its write queue.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wq_entry_t;

endpackage

// File: rtl/wq_fwd_match.sv
// Youngest-match forwarding selector over the queue entries plus the output stage.
module wq_fwd_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wq_entry_t              entries [DEPTH],
    input  logic [PTR_W-1:0]       tail,
    input  wq_entry_t              outStage,
    input  logic [REG_ADDR_W-1:0]  lookupRegister,
    output logic                   hit,
    output logic [DATA_W-1:0]      hitData
);

    logic [PTR_W-1:0] idx;

    // Scan from tail (oldest slot when full) around to tail-1 (youngest) so
    // later matches override earlier ones; the output stage is oldest of all.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        idx     = '0;
        if (lookupRegister != REG_ZERO) begin
            if (outStage.valid && outStage.regAddr == lookupRegister) begin
                hit     = 1'b1;
                hitData = outStage.data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = tail + PTR_W'(k);
                if (entries[idx].valid && entries[idx].regAddr == lookupRegister) begin
                    hit     = 1'b1;
                    hitData = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Register-file writeback queue with forwarding lookup.
// Optional WQ_COALESCE_EN: merge a write into the tail entry when the register matches.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [REG_ADDR_W-1:0] InRegister,
    input  logic [DATA_W-1:0]     InData,
    input  logic                  DrainEn,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] LookupRegister1,
    input  logic [REG_ADDR_W-1:0] LookupRegister2,
    output logic                  Hit1,
    output logic                  Hit2,
    output logic [DATA_W-1:0]     HitData1,
    output logic [DATA_W-1:0]     HitData2,
    output logic [PTR_W:0]        Count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    wq_entry_t        entries [DEPTH];
    wq_entry_t        outStage;
    logic [PTR_W-1:0] head, tail, tailPrev;
    logic [PTR_W:0]   count;
    logic             accept, push, drain, coalesce;

    // Handshake: a request transfers on any rising edge where InValid and
    // InReady are both high; InReady depends only on registered occupancy.
    assign InReady  = count < FULL_COUNT;
    assign accept   = InValid && InReady;
    assign drain    = DrainEn && (count != '0);
    assign tailPrev = tail - PTR_W'(1);

`ifdef WQ_COALESCE_EN
    // A lone entry being drained this edge cannot absorb the new data.
    assign coalesce = accept && (InRegister != REG_ZERO) && (count != '0) &&
                      (entries[tailPrev].regAddr == InRegister) &&
                      !(drain && count == (PTR_W+1)'(1));
`else
    assign coalesce = 1'b0;
`endif

    assign push = accept && (InRegister != REG_ZERO) && !coalesce;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{valid: 1'b1, regAddr: InRegister, data: InData};
                tail          <= tail + PTR_W'(1);
            end
            if (coalesce) begin
                entries[tailPrev].data <= InData;
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
                RegWrite            <= 1'b1;
                WriteRegister       <= entries[head].regAddr;
                WriteData           <= entries[head].data;
            end else begin
                RegWrite <= 1'b0;
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(drain);
        end
    end

    assign Count    = count;
    assign outStage = '{valid: RegWrite, regAddr: WriteRegister, data: WriteData};

    wq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uFwd1 (
        .entries        (entries),
        .tail           (tail),
        .outStage       (outStage),
        .lookupRegister (LookupRegister1),
        .hit            (Hit1),
        .hitData        (HitData1)
    );

    wq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uFwd2 (
        .entries        (entries),
        .tail           (tail),
        .outStage       (outStage),
        .lookupRegister (LookupRegister2),
        .hit            (Hit2),
        .hitData        (HitData2)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue (DEPTH=4); expectations follow WQ_COALESCE_EN.
module tb_regfile_write_queue;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        DrainEn;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  LookupRegister1, LookupRegister2;
    logic        Hit1, Hit2;
    logic [31:0] HitData1, HitData2;
    logic [2:0]  Count;

    int nChecks = 0;
    int nFails  = 0;

    regfile_write_queue #(.DEPTH(4)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .InValid         (InValid),
        .InReady         (InReady),
        .InRegister      (InRegister),
        .InData          (InData),
        .DrainEn         (DrainEn),
        .RegWrite        (RegWrite),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .LookupRegister1 (LookupRegister1),
        .LookupRegister2 (LookupRegister2),
        .Hit1            (Hit1),
        .Hit2            (Hit2),
        .HitData1        (HitData1),
        .HitData2        (HitData2),
        .Count           (Count)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        InValid    = v;
        InRegister = r;
        InData     = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        DrainEn = 1'b0;
        LookupRegister1 = 5'd0;
        LookupRegister2 = 5'd0;
        tick();
        tick();
        Rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_count", 32'(Count), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_wreg", 32'(WriteRegister), 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        LookupRegister1 = 5'd5;
        #1 check("rst_hit1", 32'(Hit1), 32'd0);

        // Single write with one-cycle latency to the write port
        DrainEn = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("single_count", 32'(Count), 32'd1);
        check("single_regwrite_early", 32'(RegWrite), 32'd0);
        check("single_fwd_hit", 32'(Hit1), 32'd1);
        check("single_fwd_data", HitData1, 32'hDEADBEEF);
        tick();
        check("single_regwrite", 32'(RegWrite), 32'd1);
        check("single_wreg", 32'(WriteRegister), 32'd5);
        check("single_wdata", WriteData, 32'hDEADBEEF);
        check("single_outstage_hit", 32'(Hit1), 32'd1);
        tick();
        check("single_regwrite_off", 32'(RegWrite), 32'd0);
        check("single_wreg_hold", 32'(WriteRegister), 32'd5);
        check("single_hit_gone", 32'(Hit1), 32'd0);

        // Fill to full, hold a fifth request, then drain in order
        DrainEn = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 5'(r), 32'h100 + 32'(r));
            tick();
        end
        drive(1'b1, 5'd6, 32'h600);
        check("full_count", 32'(Count), 32'd4);
        check("full_inready", 32'(InReady), 32'd0);
        tick();
        check("full_hold_count", 32'(Count), 32'd4);
        LookupRegister2 = 5'd3;
        #1 check("full_fwd_hit2", 32'(Hit2), 32'd1);
        check("full_fwd_data2", HitData2, 32'h103);
        DrainEn = 1'b1;
        tick();
        check("drain1_reg", 32'(WriteRegister), 32'd1);
        check("drain1_data", WriteData, 32'h101);
        check("drain1_count", 32'(Count), 32'd3);
        check("drain1_inready", 32'(InReady), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("drain2_reg", 32'(WriteRegister), 32'd2);
        check("drain2_count", 32'(Count), 32'd3);
        tick();
        check("drain3_reg", 32'(WriteRegister), 32'd3);
        tick();
        check("drain4_reg", 32'(WriteRegister), 32'd4);
        check("drain4_data", WriteData, 32'h104);
        tick();
        check("drain5_regwrite", 32'(RegWrite), 32'd1);
        check("drain5_reg", 32'(WriteRegister), 32'd6);
        check("drain5_data", WriteData, 32'h600);
        check("drain5_count", 32'(Count), 32'd0);
        tick();
        check("drain_done", 32'(RegWrite), 32'd0);

        // Same-register forwarding: youngest data wins
        DrainEn = 1'b0;
        LookupRegister1 = 5'd7;
        drive(1'b1, 5'd7, 32'd1);
        tick();
        drive(1'b1, 5'd7, 32'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0);
`ifdef WQ_COALESCE_EN
        check("fwd_count", 32'(Count), 32'd1);
`else
        check("fwd_count", 32'(Count), 32'd2);
`endif
        check("fwd_hit", 32'(Hit1), 32'd1);
        check("fwd_data", HitData1, 32'd2);
        DrainEn = 1'b1;
        tick();
        check("fwd_d1_reg", 32'(WriteRegister), 32'd7);
`ifdef WQ_COALESCE_EN
        check("fwd_d1_data", WriteData, 32'd2);
`else
        check("fwd_d1_data", WriteData, 32'd1);
        check("fwd_d1_prio", HitData1, 32'd2);
        tick();
        check("fwd_d2_data", WriteData, 32'd2);
        check("fwd_d2_hit", 32'(Hit1), 32'd1);
`endif
        tick();
        check("fwd_after_regwrite", 32'(RegWrite), 32'd0);
        check("fwd_after_hit", 32'(Hit1), 32'd0);
        check("fwd_after_hitdata", HitData1, 32'd0);

        // Register 0 is accepted but never stored
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        check("r0_inready", 32'(InReady), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("r0_count", 32'(Count), 32'd0);
        tick();
        check("r0_regwrite", 32'(RegWrite), 32'd0);
        LookupRegister1 = 5'd0;
        #1 check("r0_hit", 32'(Hit1), 32'd0);
        check("r0_hitdata", HitData1, 32'd0);

        // Back-to-back same register: coalesced or two entries
        DrainEn = 1'b0;
        LookupRegister2 = 5'd9;
        drive(1'b1, 5'd9, 32'd10);
        tick();
        drive(1'b1, 5'd9, 32'd11);
        tick();
        drive(1'b0, 5'd0, 32'h0);
`ifdef WQ_COALESCE_EN
        check("co_count", 32'(Count), 32'd1);
`else
        check("co_count", 32'(Count), 32'd2);
`endif
        check("co_hitdata", HitData2, 32'd11);
        DrainEn = 1'b1;
        tick();
        check("co_c1_regwrite", 32'(RegWrite), 32'd1);
        check("co_c1_reg", 32'(WriteRegister), 32'd9);
`ifdef WQ_COALESCE_EN
        check("co_c1_data", WriteData, 32'd11);
        tick();
        check("co_c2_regwrite", 32'(RegWrite), 32'd0);
`else
        check("co_c1_data", WriteData, 32'd10);
        tick();
        check("co_c2_regwrite", 32'(RegWrite), 32'd1);
        check("co_c2_data", WriteData, 32'd11);
        tick();
        check("co_c3_regwrite", 32'(RegWrite), 32'd0);
`endif

        // Asynchronous reset mid-cycle with pending entries and a live output stage
        DrainEn = 1'b0;
        for (int r = 10; r <= 13; r++) begin
            drive(1'b1, 5'(r), 32'hA0 + 32'(r));
            tick();
        end
        drive(1'b0, 5'd0, 32'h0);
        DrainEn = 1'b1;
        tick();
        DrainEn = 1'b0;
        check("mid_pre_count", 32'(Count), 32'd3);
        check("mid_pre_regwrite", 32'(RegWrite), 32'd1);
        LookupRegister1 = 5'd11;
        #1 check("mid_pre_hit", 32'(Hit1), 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(Count), 32'd0);
        check("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        check("mid_rst_wreg", 32'(WriteRegister), 32'd0);
        check("mid_rst_hit", 32'(Hit1), 32'd0);
        #1 Rst_n = 1'b1;
        DrainEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_post_regwrite", 32'(RegWrite), 32'd0);
        end
        check("mid_post_count", 32'(Count), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
